// File: rtl/uart_host_loader.sv
// Host-side serial boot loader: waits for sync, sends the length header and program image,
// waits for the data sync, streams the data image and queues every byte the CPU sends back.
module uart_host_loader #(
  parameter int         WORD_BYTES  = 4,
  parameter int         INSTR_DEPTH = 1024,
  parameter int         DATA_DEPTH  = 1024,
  parameter logic [7:0] SYNC_PROG   = 8'h99,
  parameter logic [7:0] SYNC_DATA   = 8'hAA,
  parameter bit         SYNC_STRICT = 1'b1,
  parameter bit         MSB_FIRST   = 1'b0,
  parameter int         RES_DEPTH   = 64,
  localparam int        AW    = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1,
  localparam int        DW    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int        WBITS = 8 * WORD_BYTES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      instr_words,
  input  logic [31:0]      data_words,
  output logic [AW-1:0]    prog_addr,
  input  logic [WBITS-1:0] prog_rdata,
  output logic [DW-1:0]    data_addr,
  input  logic [WBITS-1:0] data_rdata,
  output logic             tx_start,
  output logic [7:0]       sdata,
  input  logic             tx_busy,
  input  logic             rx_ready,
  input  logic [7:0]       rdata,
  input  logic             ferr,
  output logic             res_valid,
  output logic [7:0]       res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err_flags
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PSYNC, S_SEND_HDR, S_SEND_PROG, S_WAIT_DSYNC, S_SEND_DATA, S_DONE
  } state_t;

  typedef enum logic [1:0] {F_ADDR, F_LOAD, F_SEND} fetch_t;

  state_t            state_reg;
  fetch_t            fetch_reg;
  logic [31:0]       instr_n_reg;
  logic [31:0]       data_n_reg;
  logic [31:0]       word_cnt_reg;
  logic [31:0]       hdr_sh_reg;
  logic [WBITS-1:0]  word_sh_reg;
  logic [3:0]        byte_cnt_reg;
  logic [AW-1:0]     prog_addr_reg;
  logic [DW-1:0]     data_addr_reg;
  logic              tx_start_reg;
  logic [7:0]        sdata_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              sync_err_reg;
  logic              frame_err_reg;
  logic              ovf_err_reg;

  logic [7:0]        fifo_mem [RES_DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              res_valid_reg;
  logic [7:0]        res_data_reg;

  logic              start_ok;
  logic              rx_good;
  logic              can_tx;
  logic              sync_ok;
  logic [7:0]        sync_byte;
  logic [31:0]       hdr_raw;
  logic [31:0]       hdr_ord;
  logic [WBITS-1:0]  rom_word;
  logic [WBITS-1:0]  word_ord;
  logic [31:0]       cur_n;
  logic              word_last;
  logic              byte_last;

  logic              fifo_full;
  logic              pop;
  logic              push_req;
  logic              push;
  logic              overflow_hit;
  logic [PW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     remaining;

  assign start_ok  = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign rx_good   = rx_ready && !ferr;
  // One idle cycle is forced after every tx_start so UartTx has time to raise tx_busy.
  assign can_tx    = !tx_busy && !tx_start_reg;
  assign sync_byte = (state_reg == S_WAIT_PSYNC) ? SYNC_PROG : SYNC_DATA;
  assign sync_ok   = !SYNC_STRICT || (rdata == sync_byte);
  assign hdr_raw   = instr_words * 32'(WORD_BYTES);
  assign rom_word  = (state_reg == S_SEND_PROG) ? prog_rdata : data_rdata;
  assign cur_n     = (state_reg == S_SEND_PROG) ? instr_n_reg : data_n_reg;
  assign word_last = (word_cnt_reg == cur_n - 32'd1);
  assign byte_last = (byte_cnt_reg == 4'(WORD_BYTES - 1));

  // Byte order is resolved once at load time so the shifters always emit the low byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hdr_order
      assign hdr_ord[8*gi +: 8] = MSB_FIRST ? hdr_raw[8*(3-gi) +: 8] : hdr_raw[8*gi +: 8];
    end
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_word_order
      assign word_ord[8*gi +: 8] = MSB_FIRST ? rom_word[8*(WORD_BYTES-1-gi) +: 8]
                                             : rom_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      fetch_reg     <= F_ADDR;
      instr_n_reg   <= '0;
      data_n_reg    <= '0;
      word_cnt_reg  <= '0;
      hdr_sh_reg    <= '0;
      word_sh_reg   <= '0;
      byte_cnt_reg  <= '0;
      prog_addr_reg <= '0;
      data_addr_reg <= '0;
      tx_start_reg  <= 1'b0;
      sdata_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sync_err_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      if (rx_ready && ferr) frame_err_reg <= 1'b1;
      if (overflow_hit) ovf_err_reg <= 1'b1;

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            instr_n_reg   <= instr_words;
            data_n_reg    <= data_words;
            hdr_sh_reg    <= hdr_ord;
            sync_err_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            ovf_err_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= S_WAIT_PSYNC;
          end
        end

        S_WAIT_PSYNC, S_WAIT_DSYNC: begin
          if (rx_good) begin
            if (!sync_ok) begin
              sync_err_reg <= 1'b1;
            end else if (state_reg == S_WAIT_PSYNC) begin
              byte_cnt_reg <= '0;
              state_reg    <= S_SEND_HDR;
            end else if (data_n_reg == 32'd0) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              data_addr_reg <= '0;
              word_cnt_reg  <= '0;
              fetch_reg     <= F_ADDR;
              state_reg     <= S_SEND_DATA;
            end
          end
        end

        S_SEND_HDR: begin
          if (can_tx) begin
            tx_start_reg <= 1'b1;
            sdata_reg    <= hdr_sh_reg[7:0];
            hdr_sh_reg   <= hdr_sh_reg >> 8;
            byte_cnt_reg <= byte_cnt_reg + 4'd1;
            if (byte_cnt_reg == 4'd3) begin
              if (instr_n_reg == 32'd0) begin
                state_reg <= S_WAIT_DSYNC;
              end else begin
                prog_addr_reg <= '0;
                word_cnt_reg  <= '0;
                fetch_reg     <= F_ADDR;
                state_reg     <= S_SEND_PROG;
              end
            end
          end
        end

        S_SEND_PROG, S_SEND_DATA: begin
          case (fetch_reg)
            // The address was registered on entry; the ROM samples it during this cycle.
            F_ADDR: fetch_reg <= F_LOAD;
            F_LOAD: begin
              word_sh_reg  <= word_ord;
              byte_cnt_reg <= '0;
              fetch_reg    <= F_SEND;
            end
            default: begin
              if (can_tx) begin
                tx_start_reg <= 1'b1;
                sdata_reg    <= word_sh_reg[7:0];
                word_sh_reg  <= word_sh_reg >> 8;
                byte_cnt_reg <= byte_cnt_reg + 4'd1;
                if (byte_last) begin
                  fetch_reg <= F_ADDR;
                  if (word_last) begin
                    if (state_reg == S_SEND_PROG) begin
                      state_reg <= S_WAIT_DSYNC;
                    end else begin
                      busy_reg  <= 1'b0;
                      done_reg  <= 1'b1;
                      state_reg <= S_DONE;
                    end
                  end else begin
                    word_cnt_reg <= word_cnt_reg + 32'd1;
                    if (state_reg == S_SEND_PROG)
                      prog_addr_reg <= (prog_addr_reg == AW'(INSTR_DEPTH - 1)) ? '0
                                       : prog_addr_reg + AW'(1);
                    else
                      data_addr_reg <= (data_addr_reg == DW'(DATA_DEPTH - 1)) ? '0
                                       : data_addr_reg + DW'(1);
                  end
                end
              end
            end
          endcase
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Result FIFO: storage array plus a registered head byte.
  assign fifo_full    = (count_reg == CW'(RES_DEPTH));
  assign pop          = res_ready && res_valid_reg;
  assign push_req     = rx_good && (state_reg == S_SEND_DATA || state_reg == S_DONE) && !start_ok;
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_hit = push_req && fifo_full && !pop;
  assign rd_ptr_next  = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  assign remaining    = pop ? count_reg - CW'(1) : count_reg;
  assign count_next   = push ? remaining + CW'(1) : remaining;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= rdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else if (start_ok) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      res_valid_reg <= (count_next != '0);
      // When nothing else is queued the incoming byte bypasses the array straight to the head.
      if (count_next != '0)
        res_data_reg <= (remaining == '0) ? rdata : fifo_mem[rd_ptr_next];
    end
  end

  assign prog_addr = prog_addr_reg;
  assign data_addr = data_addr_reg;
  assign tx_start  = tx_start_reg;
  assign sdata     = sdata_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_flags = {ovf_err_reg, frame_err_reg, sync_err_reg};

endmodule
